// File: rtl/bcd7segs_mux.sv
// bcd7segs_mux: scans a DIGITS-wide BCD word onto a common-anode display with dead time, leading-zero blanking and frame-synchronous updates
module bcd7segs_mux #(
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 1000,
    parameter bit LZ_SUPPRESS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  pending,
    output logic                  frame
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);

    logic [CW-1:0]       count;
    logic [IW-1:0]       index;
    logic [4*DIGITS-1:0] shadow;
    logic [4*DIGITS-1:0] disp;
    logic                wrapped;
    logic                tick;
    logic                wrap;
    logic [3:0]          cur;
    logic [DIGITS-1:0]   lead;
    logic                all_zero;
    logic [6:0]          seg_next;
    logic [DIGITS-1:0]   dig_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'h7F;
        endcase
    endfunction

    assign tick = count == CW'(SCAN_DIV - 1);
    assign wrap = tick && index == IW'(DIGITS - 1);
    assign cur  = disp[{index, 2'b00} +: 4];

    // Mark digits that sit inside a run of zeros reaching the most significant digit
    always_comb begin
        lead     = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            all_zero = all_zero && disp[4*i +: 4] == 4'd0;
            lead[i]  = all_zero;
        end
    end

    // Next pin values for the digit currently selected by the scan
    always_comb begin
        seg_next = (LZ_SUPPRESS && lead[index]) ? 7'h7F : decode(cur);
        dig_next = (count == '0) ? '1 : ~(DIGITS'(1) << index);
    end

    // Prescaler and digit index; the index wraps at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            index <= '0;
        end else begin
            count <= tick ? '0 : count + CW'(1);
            if (tick) index <= wrap ? '0 : index + IW'(1);
        end
    end

    // Shadow capture and tear-free promotion to the display register at frame boundaries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '1;
            disp    <= '1;
            pending <= 1'b0;
        end else begin
            if (load) shadow <= bcd_in;
            if (wrap) begin
                disp    <= load ? bcd_in : pending ? shadow : disp;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Registered pin drivers; frame is delayed so it lines up with slot 0's dead cycle on the pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg     <= 7'h7F;
            dig_n   <= '1;
            wrapped <= 1'b0;
            frame   <= 1'b0;
        end else begin
            seg     <= seg_next;
            dig_n   <= dig_next;
            wrapped <= wrap;
            frame   <= wrapped;
        end
    end
endmodule

// File: tb/tb_bcd7segs_mux.sv
// tb_bcd7segs_mux: randomized scoreboard bench for the multiplexed 7-segment driver
module tb_bcd7segs_mux;
    localparam int D = 4;
    localparam int S = 4;
    localparam int F = D * S;

    typedef struct {
        int          e;
        logic [15:0] v;
    } ld_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = 16'h0;
    logic [6:0]  seg, seg_nolz;
    logic [3:0]  dig_n, dig_n_nolz;
    logic        pending, pending_nolz, frame, frame_nolz;

    int          compared = 0;
    int          mismatched = 0;
    int          edges;
    ld_t         loads[$];
    logic [6:0]  tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    bcd7segs_mux #(.DIGITS(D), .SCAN_DIV(S), .LZ_SUPPRESS(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in),
        .seg(seg), .dig_n(dig_n), .pending(pending), .frame(frame)
    );

    bcd7segs_mux #(.DIGITS(D), .SCAN_DIV(S), .LZ_SUPPRESS(1'b0)) u_nolz (
        .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in),
        .seg(seg_nolz), .dig_n(dig_n_nolz), .pending(pending_nolz), .frame(frame_nolz)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else edges <= edges + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
        end
    endtask

    // Segment pattern a digit must show, from the display rules alone
    function automatic logic [6:0] ref_seg(input logic [15:0] w, input int i, input bit lz);
        logic [3:0] d;
        d = w[4*i +: 4];
        if (d > 4'd9) return 7'h7F;
        if (lz && i > 0 && (w >> (4 * i)) == 16'h0) return 7'h7F;
        return tab[d];
    endfunction

    // Monitor: consumes captured loads and compares every output each cycle
    initial begin
        logic [15:0] disp_now, disp_prev, latest_v;
        int          latest_e, p;
        logic [3:0]  exp_dig;
        disp_now = 16'hFFFF;
        latest_v = 16'hFFFF;
        latest_e = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                loads.delete();
                disp_now = 16'hFFFF;
                latest_v = 16'hFFFF;
                latest_e = 0;
                check("rst_seg", seg, 7'h7F);
                check("rst_dig", dig_n, 4'hF);
                check("rst_pending", pending, 1'b0);
                check("rst_frame", frame, 1'b0);
                check("rst_seg_nolz", seg_nolz, 7'h7F);
            end else begin
                disp_prev = disp_now;
                while (loads.size() > 0 && loads[0].e <= edges) begin
                    latest_e = loads[0].e;
                    latest_v = loads[0].v;
                    void'(loads.pop_front());
                end
                if (edges > 0 && edges % F == 0) disp_now = latest_v;
                p = (edges > 0) ? (edges - 1) % F : 0;
                exp_dig = (edges == 0 || p % S == 0) ? 4'hF : ~(4'b1 << (p / S));
                check("dig_n", dig_n, exp_dig);
                check("dig_n_nolz", dig_n_nolz, exp_dig);
                check("seg", seg, edges == 0 ? 7'h7F : ref_seg(disp_prev, p / S, 1'b1));
                check("seg_nolz", seg_nolz, edges == 0 ? 7'h7F : ref_seg(disp_prev, p / S, 1'b0));
                check("frame", frame, edges >= F + 1 && p == 0);
                check("pending", pending, latest_e > F * (edges / F));
                check("pending_nolz", pending_nolz, latest_e > F * (edges / F));
            end
        end
    end

    function automatic logic [15:0] rand_bcd();
        logic [15:0] w;
        for (int i = 0; i < D; i++)
            w[4*i +: 4] = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom_range(0, 10));
        return w;
    endfunction

    task automatic do_load(input logic [15:0] v);
        load   = 1'b1;
        bcd_in = v;
        loads.push_back('{edges + 1, v});
        @(negedge clk);
        load   = 1'b0;
        bcd_in = 16'($urandom);
    endtask

    task automatic wait_slot(input int pos);
        while ((edges + 1) % F != pos) @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        run(3);
        #1 rst_n = 1'b1;
        run(20);
        do_load(16'h1234);
        run(2 * F + 20);
        wait_slot(6);
        do_load(16'h0008);
        run(2 * F);
        wait_slot(0);
        do_load(16'h0042);
        run(2 * F);
        wait_slot(3);
        do_load(16'h0000);
        run(2 * F);
        wait_slot(11);
        do_load(16'h0A05);
        run(2 * F);
        wait_slot(2);
        do_load(16'h1111);
        do_load(16'h2222);
        run(2 * F);
        for (int k = 0; k < 30; k++) begin
            run($urandom_range(1, 20));
            do_load(rand_bcd());
        end
        run(2 * F);
        wait_slot(9);
        do_load(16'h5555);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_seg", seg, 7'h7F);
        check("async_rst_dig", dig_n, 4'hF);
        check("async_rst_pending", pending, 1'b0);
        check("async_rst_frame", frame, 1'b0);
        run(2);
        #1 rst_n = 1'b1;
        run(2 * F);
        do_load(16'h9876);
        run(2 * F);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/bcd7segs_mux.md
# bcd7segs_mux

Multiplexed multi-digit BCD-to-7-segment display driver. Holds a DIGITS-wide BCD word, scans the digits one at a time onto a shared active-low segment bus with active-low digit enables, and adds per-digit dead time, leading-zero suppression and tear-free frame-synchronous updates. It sits between the datapath that produces BCD results and the board's common-anode display.

## Interface
- DIGITS, 4: number of BCD digits scanned; valid range 2..8.
- SCAN_DIV, 1000: clock cycles per digit slot; valid range 2..65535.
- LZ_SUPPRESS, 1: 1 blanks leading zeros, 0 shows every digit.

- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle strobe: capture bcd_in for display.
- bcd_in  in  4*DIGITS  BCD word; digit i is bcd_in[4i+3:4i], where digit 0 is least significant.
- seg  out  7  active-low segments; seg[6]=a, seg[5]=b, ..., seg[0]=g.
- dig_n  out  DIGITS  active-low digit enables, one-hot-low or all-high.
- pending  out  1  high while a captured word waits for the next frame boundary.
- frame  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- **Prescaler**
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick = (count == SCAN_DIV-1).
- **Digit index**
  - Advances on tick, from DIGITS-1 back to 0.
  - A wrap is a frame boundary.
- **Update path**
  - load=1 copies bcd_in into the shadow register and sets pending.
  - At a frame boundary with pending=1, shadow is copied to the display register and pending clears.
  - If load=1 on the boundary cycle, bcd_in goes straight to the display register and pending stays 0.
  - The display register never changes mid-frame.
- **Decode**
  - Active-low segments: 0 drives a–f, 1 drives b,c, 2 drives a,b,d,e,g, 3 drives a,b,c,d,g, 4 drives b,c,f,g, 5 drives a,c,d,f,g, 6 drives a,c,d,e,f,g, 7 drives a,b,c, 8 drives all, 9 drives a,b,c,d,f,g.
  - Codes 10–15 blank (seg=7'h7F).
- **Leading-zero suppression** (LZ_SUPPRESS=1)
  - Digit i>0 is blanked when it and every more significant digit equal 0.
  - Digit 0 is never suppressed.
  - An invalid code counts as non-zero, so it stops suppression but is itself blank.
- **Dead time**: in each slot's first cycle (count==0) dig_n is all ones, to suppress ghosting.

## Timing
- **Reset values** (async, while rst_n=0):
  - count=0, index=0, pending=0, frame=0.
  - Shadow and display registers all 4'hF (blank).
  - seg=7'h7F, dig_n all ones.
- **Registered outputs**
  - seg, dig_n and frame are registered.
  - They reflect count/index/display one cycle later.
- **Slot timing**
  - A slot lasts SCAN_DIV cycles: 1 dead cycle, then SCAN_DIV-1 cycles with dig_n[index]=0.
  - A frame lasts DIGITS*SCAN_DIV cycles.
- **pending / frame**
  - pending rises the cycle after load.
  - frame is asserted in the first cycle of slot 0 of each frame (dead cycle), coincident with the first cycle that dig_n reflects the new display register.
  - pending falls at the frame boundary edge.
- **Load latency**: the new value reaches the pins on the first frame boundary after load; worst case DIGITS*SCAN_DIV+1 cycles.
- **Repeated load**: loads while pending=1 overwrite the shadow, last-write-wins.
- **Reset mid-frame**: everything returns to reset values immediately. The first digit-0 slot after release shows blank until a load and a frame boundary.

## Test plan
- **Reset**
  - Stimulus: assert rst_n=0 mid-scan with DIGITS=4, SCAN_DIV=4.
  - Required: seg=7'h7F, dig_n=4'hF, pending=0 the same cycle, without a clk edge.
- **Scan sequence and dead time**
  - Stimulus: load 16'h1234 and run two frames.
  - Required, per 4-cycle slot: dig_n = F,E,E,E, F,D,D,D, F,B,B,B, F,7,7,7.
  - Required segments, in slot order: seg=7'b1001100 (4), 7'b0000110 (3), 7'b0010010 (2), 7'b1001111 (1).
  - Required: frame pulses once per 16 cycles.
- **Frame-synchronous update**
  - Stimulus: load 16'h0008 mid-frame.
  - Required: pending=1 until the boundary; old digits are held until the boundary; pending=0 after it.
  - Required after the boundary, with LZ_SUPPRESS=1: digits 3..1 blank (7'h7F) and digit 0 shows 7'b0000000.
- **Load on the boundary cycle**
  - Stimulus: pulse load with 16'h0042 on the tick of slot 3.
  - Required: the next frame displays 42 immediately and pending never rises.
- **Suppression edge cases**
  - Stimulus: load 16'h0000. Required: only digit 0 is lit, showing 7'b0000001.
  - Stimulus: load 16'h0A05. Required: digit 3 blank, digit 2 blank (invalid code), digit 1 shows 0, digit 0 shows 5.
  - Stimulus: LZ_SUPPRESS=0 with 16'h0000. Required: four zeros displayed.
- **Back-to-back loads**
  - Stimulus: load 16'h1111 then 16'h2222 in the same frame.
  - Required: only 2222 appears at the next boundary.
